// File: rtl/ibex_ex_issue.sv
// ============================================================================
// Module   : ibex_ex_issue
// Brief    : ID-stage issue/retire controller for the execute block, owning the
//            multi-cycle intermediate-value registers and a registered WB port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_ex_issue #(
    parameter int unsigned RV32M = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [1:0]  op_class_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic        rf_we_i,
    input  logic        flush_i,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic        alu_instr_first_cycle_o,
    output logic        multdiv_ready_id_o,
    input  logic        ex_valid_i,
    input  logic [31:0] result_ex_i,
    input  logic [1:0]  imd_val_we_i,
    input  logic [67:0] imd_val_d_i,
    output logic [67:0] imd_val_q_o,
    input  logic        wb_ready_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        illegal_o,
    output logic [5:0]  exec_cycles_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    localparam logic       C_M_EN    = (RV32M != 32'd0);
    localparam logic [5:0] C_CNT_MAX = 6'd63;

    state_e      r_state;
    logic [1:0]  r_cls;
    logic [4:0]  r_waddr;
    logic        r_we;
    logic [5:0]  r_cnt;
    logic        r_first;
    logic [33:0] r_imd [2];

    logic w_exec;
    logic w_retire;
    logic w_accept;
    logic w_illegal;
    logic w_start;

    assign w_exec    = (r_state == EXEC);
    // Flush wins over a retire that lands in the same cycle.
    assign w_retire  = w_exec & ex_valid_i & wb_ready_i & ~flush_i;
    assign w_accept  = instr_valid_i & instr_ready_o;
    assign w_illegal = w_accept & ~C_M_EN & op_class_i[1];
    assign w_start   = w_accept & ~w_illegal;

    assign instr_ready_o           = ~w_exec | w_retire;
    assign mult_sel_o              = w_exec & C_M_EN & (r_cls == 2'd2);
    assign div_sel_o               = w_exec & C_M_EN & (r_cls == 2'd3);
    assign mult_en_o               = mult_sel_o;
    assign div_en_o                = div_sel_o;
    assign alu_instr_first_cycle_o = w_exec & r_first;
    assign multdiv_ready_id_o      = w_exec & wb_ready_i;
    assign busy_o                  = w_exec;
    assign imd_val_q_o             = {r_imd[1], r_imd[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_cls         <= 2'd0;
            r_waddr       <= 5'd0;
            r_we          <= 1'b0;
            r_cnt         <= 6'd0;
            r_first       <= 1'b0;
            wb_valid_o    <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_waddr_o    <= 5'd0;
            wb_wdata_o    <= 32'd0;
            exec_cycles_o <= 6'd0;
            illegal_o     <= 1'b0;
        end else begin
            illegal_o  <= w_illegal;
            wb_valid_o <= w_retire;

            if (w_retire) begin
                wb_we_o       <= r_we;
                wb_waddr_o    <= r_waddr;
                wb_wdata_o    <= result_ex_i;
                exec_cycles_o <= r_cnt;
            end

            // A back-to-back accept overrides the return to IDLE.
            if (w_start) begin
                r_state <= EXEC;
                r_cls   <= op_class_i;
                r_waddr <= rf_waddr_i;
                r_we    <= rf_we_i;
                r_cnt   <= 6'd1;
                r_first <= 1'b1;
            end else if (w_exec && (w_retire || flush_i)) begin
                r_state <= IDLE;
                r_first <= 1'b0;
            end else if (w_exec) begin
                r_first <= 1'b0;
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imd[0] <= 34'd0;
            r_imd[1] <= 34'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_exec && imd_val_we_i[i]) begin
                    r_imd[i] <= imd_val_d_i[34*i +: 34];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibex_ex_issue.sv
// ============================================================================
// Module   : tb_ibex_ex_issue
// Brief    : Self-checking bench for ibex_ex_issue (RV32M=2 and RV32M=0 copies).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_ex_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [1:0]  op_class;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic        flush;
    logic        ex_valid;
    logic [31:0] result;
    logic [1:0]  imd_we;
    logic [67:0] imd_d;
    logic        wb_ready;

    logic        ready_1, mult_en_1, div_en_1, mult_sel_1, div_sel_1, first_1, mdr_1;
    logic        wb_valid_1, wb_we_1, illegal_1, busy_1;
    logic [4:0]  wb_waddr_1;
    logic [31:0] wb_wdata_1;
    logic [67:0] imd_q_1;
    logic [5:0]  exec_1;

    logic        ready_0, mult_en_0, div_en_0, mult_sel_0, div_sel_0, first_0, mdr_0;
    logic        wb_valid_0, wb_we_0, illegal_0, busy_0;
    logic [4:0]  wb_waddr_0;
    logic [31:0] wb_wdata_0;
    logic [67:0] imd_q_0;
    logic [5:0]  exec_0;

    int checks = 0;
    int errors = 0;

    ibex_ex_issue #(.RV32M(2)) u_dut_m (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(ready_1),
        .op_class_i(op_class), .rf_waddr_i(rf_waddr), .rf_we_i(rf_we), .flush_i(flush),
        .mult_en_o(mult_en_1), .div_en_o(div_en_1), .mult_sel_o(mult_sel_1), .div_sel_o(div_sel_1),
        .alu_instr_first_cycle_o(first_1), .multdiv_ready_id_o(mdr_1), .ex_valid_i(ex_valid),
        .result_ex_i(result), .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q_1),
        .wb_ready_i(wb_ready), .wb_valid_o(wb_valid_1), .wb_we_o(wb_we_1), .wb_waddr_o(wb_waddr_1),
        .wb_wdata_o(wb_wdata_1), .illegal_o(illegal_1), .exec_cycles_o(exec_1), .busy_o(busy_1)
    );

    ibex_ex_issue #(.RV32M(0)) u_dut_nom (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(ready_0),
        .op_class_i(op_class), .rf_waddr_i(rf_waddr), .rf_we_i(rf_we), .flush_i(flush),
        .mult_en_o(mult_en_0), .div_en_o(div_en_0), .mult_sel_o(mult_sel_0), .div_sel_o(div_sel_0),
        .alu_instr_first_cycle_o(first_0), .multdiv_ready_id_o(mdr_0), .ex_valid_i(ex_valid),
        .result_ex_i(result), .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q_0),
        .wb_ready_i(wb_ready), .wb_valid_o(wb_valid_0), .wb_we_o(wb_we_0), .wb_waddr_o(wb_waddr_0),
        .wb_wdata_o(wb_wdata_0), .illegal_o(illegal_0), .exec_cycles_o(exec_0), .busy_o(busy_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one in-flight op with its elapsed cycle count, plus
    // the registered writeback/illegal/imd observations it must produce.
    typedef struct packed {
        bit        busy;
        bit [1:0]  cls;
        bit [4:0]  waddr;
        bit        we;
        bit [6:0]  cnt;
        bit        wb_valid;
        bit        wb_we;
        bit [4:0]  wb_waddr;
        bit [31:0] wb_wdata;
        bit [5:0]  exec;
        bit        illegal;
        bit [67:0] imd;
    } model_t;

    model_t m1, m0;
    bit     m_ok = 1'b0;

    function automatic bit exp_ready(model_t s);
        return !s.busy || (ex_valid && wb_ready && !flush);
    endfunction

    function automatic model_t step(model_t s, bit mext);
        model_t n;
        n = s;
        n.wb_valid = 1'b0;
        n.illegal  = 1'b0;
        if (s.busy) begin
            if (imd_we[0]) n.imd[33:0]  = imd_d[33:0];
            if (imd_we[1]) n.imd[67:34] = imd_d[67:34];
            if (flush) begin
                n.busy = 1'b0;
            end else if (ex_valid && wb_ready) begin
                n.busy     = 1'b0;
                n.wb_valid = 1'b1;
                n.wb_we    = s.we;
                n.wb_waddr = s.waddr;
                n.wb_wdata = result;
                n.exec     = s.cnt[5:0];
            end else if (s.cnt < 7'd63) begin
                n.cnt = s.cnt + 7'd1;
            end
        end
        if (instr_valid && exp_ready(s)) begin
            if (!mext && op_class >= 2'd2) begin
                n.illegal = 1'b1;
            end else begin
                n.busy  = 1'b1;
                n.cls   = op_class;
                n.waddr = rf_waddr;
                n.we    = rf_we;
                n.cnt   = 7'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1   = '0;
            m0   = '0;
            m_ok = 1'b1;
        end else begin
            m1 = step(m1, 1'b1);
            m0 = step(m0, 1'b0);
        end
    end

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input model_t m, input bit mext,
                           input logic rdy, input logic men, input logic den,
                           input logic msel, input logic dsel, input logic fst,
                           input logic mdr, input logic wbv, input logic wbwe,
                           input logic [4:0] wba, input logic [31:0] wbd,
                           input logic ill, input logic [5:0] ec,
                           input logic [67:0] imq, input logic bsy);
        bit exp_m, exp_d;
        exp_m = m.busy && mext && (m.cls == 2'd2);
        exp_d = m.busy && mext && (m.cls == 2'd3);
        chk({tag, ".instr_ready"}, 68'(rdy), 68'(exp_ready(m)));
        chk({tag, ".busy"}, 68'(bsy), 68'(m.busy));
        chk({tag, ".mult_en"}, 68'(men), 68'(exp_m));
        chk({tag, ".div_en"}, 68'(den), 68'(exp_d));
        chk({tag, ".mult_sel"}, 68'(msel), 68'(exp_m));
        chk({tag, ".div_sel"}, 68'(dsel), 68'(exp_d));
        chk({tag, ".first_cycle"}, 68'(fst), 68'(m.busy && m.cnt == 7'd1));
        if (m.busy) chk({tag, ".multdiv_ready"}, 68'(mdr), 68'(wb_ready));
        chk({tag, ".wb_valid"}, 68'(wbv), 68'(m.wb_valid));
        chk({tag, ".wb_we"}, 68'(wbwe), 68'(m.wb_we));
        chk({tag, ".wb_waddr"}, 68'(wba), 68'(m.wb_waddr));
        chk({tag, ".wb_wdata"}, 68'(wbd), 68'(m.wb_wdata));
        chk({tag, ".illegal"}, 68'(ill), 68'(m.illegal));
        chk({tag, ".exec_cycles"}, 68'(ec), 68'(m.exec));
        chk({tag, ".imd_val_q"}, imq, m.imd);
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            cmp_dut("m", m1, 1'b1, ready_1, mult_en_1, div_en_1, mult_sel_1, div_sel_1, first_1,
                    mdr_1, wb_valid_1, wb_we_1, wb_waddr_1, wb_wdata_1, illegal_1, exec_1,
                    imd_q_1, busy_1);
            cmp_dut("nom", m0, 1'b0, ready_0, mult_en_0, div_en_0, mult_sel_0, div_sel_0, first_0,
                    mdr_0, wb_valid_0, wb_we_0, wb_waddr_0, wb_wdata_0, illegal_0, exec_0,
                    imd_q_0, busy_0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; op_class = 2'd0; rf_waddr = 5'd0; rf_we = 1'b0;
        flush = 1'b0; ex_valid = 1'b0; result = 32'd0; imd_we = 2'b00;
        imd_d = '0; wb_ready = 1'b1;
    endtask

    task automatic issue(input logic [1:0] cls, input logic [4:0] wa);
        instr_valid = 1'b1; op_class = cls; rf_waddr = wa; rf_we = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    logic [67:0] last_imd;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset.instr_ready", 68'(ready_1), 68'd1);
        chk("reset.wb_valid", 68'(wb_valid_1), 68'd0);
        chk("reset.exec_cycles", 68'(exec_1), 68'd0);
        chk("reset.imd_val_q", imd_q_1, 68'd0);

        // Single-cycle ALU op.
        issue(2'd0, 5'd5);
        ex_valid = 1'b1; result = 32'h0000_002A;
        tick();
        chk("alu.wb_valid", 68'(wb_valid_1), 68'd1);
        chk("alu.wb_waddr", 68'(wb_waddr_1), 68'd5);
        chk("alu.wb_wdata", 68'(wb_wdata_1), 68'h2A);
        chk("alu.exec_cycles", 68'(exec_1), 68'd1);
        ex_valid = 1'b0;
        tick();
        chk("alu.wb_pulse_end", 68'(wb_valid_1), 68'd0);

        // Three back-to-back single-cycle ops.
        issue(2'd0, 5'd1);
        ex_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            result = 32'(i);
            instr_valid = (i < 3); rf_waddr = 5'(i + 1);
            #1;
            chk("b2b.instr_ready", 68'(ready_1), 68'd1);
            tick();
            chk("b2b.wb_valid", 68'(wb_valid_1), 68'd1);
            chk("b2b.wb_wdata", 68'(wb_wdata_1), 68'(i));
        end
        idle_inputs();
        tick();

        // DIV retiring in EXEC cycle 37 with intermediate writes every cycle.
        issue(2'd3, 5'd9);
        imd_we = 2'b11;
        for (int k = 1; k <= 37; k++) begin
            imd_d = {4'(k), 32'($urandom), 32'($urandom)};
            last_imd = imd_d;
            ex_valid = (k == 37);
            result = 32'hD1D1_0000 + 32'(k);
            chk("div.div_en", 68'(div_en_1), 68'd1);
            chk("div.first_cycle", 68'(first_1), 68'(k == 1));
            tick();
        end
        idle_inputs();
        chk("div.wb_valid", 68'(wb_valid_1), 68'd1);
        chk("div.exec_cycles", 68'(exec_1), 68'd37);
        chk("div.imd_val_q", imd_q_1, last_imd);

        // MULT with writeback backpressure for four cycles.
        issue(2'd2, 5'd12);
        ex_valid = 1'b1; wb_ready = 1'b0; result = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mul.multdiv_ready", 68'(mdr_1), 68'd0);
            tick();
            chk("mul.no_wb", 68'(wb_valid_1), 68'd0);
        end
        wb_ready = 1'b1;
        tick();
        chk("mul.wb_valid", 68'(wb_valid_1), 68'd1);
        chk("mul.exec_cycles", 68'(exec_1), 68'd5);
        idle_inputs();
        tick();
        chk("mul.single_pulse", 68'(wb_valid_1), 68'd0);

        // Flush in DIV EXEC cycle 3, then flush coinciding with ex_valid.
        issue(2'd3, 5'd3);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", 68'(busy_1), 68'd0);
        chk("flush.div_en", 68'(div_en_1), 68'd0);
        chk("flush.wb_valid", 68'(wb_valid_1), 68'd0);
        chk("flush.exec_cycles", 68'(exec_1), 68'd5);
        issue(2'd3, 5'd3);
        flush = 1'b1; ex_valid = 1'b1;
        tick();
        idle_inputs();
        chk("flushret.wb_valid", 68'(wb_valid_1), 68'd0);
        chk("flushret.busy", 68'(busy_1), 68'd0);

        // MULT on the RV32M=0 copy.
        issue(2'd2, 5'd7);
        chk("nom.illegal", 68'(illegal_0), 68'd1);
        chk("nom.busy", 68'(busy_0), 68'd0);
        chk("nom.mult_en", 68'(mult_en_0), 68'd0);
        tick();
        chk("nom.illegal_pulse", 68'(illegal_0), 68'd0);
        chk("nom.wb_valid", 68'(wb_valid_0), 68'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Async reset in the middle of a multi-cycle op.
        issue(2'd1, 5'd4);
        imd_we = 2'b11; imd_d = {68{1'b1}};
        tick();
        imd_we = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy", 68'(busy_1), 68'd0);
        chk("rst.instr_ready", 68'(ready_1), 68'd1);
        chk("rst.imd_val_q", imd_q_1, 68'd0);
        chk("rst.exec_cycles", 68'(exec_1), 68'd0);
        chk("rst.first_cycle", 68'(first_1), 68'd0);
        chk("rst.wb_waddr", 68'(wb_waddr_1), 68'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            instr_valid = ($urandom_range(0, 1) == 1);
            op_class    = 2'($urandom);
            rf_waddr    = 5'($urandom);
            rf_we       = 1'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            ex_valid    = ($urandom_range(0, 9) < 3);
            wb_ready    = ($urandom_range(0, 3) != 0);
            result      = $urandom;
            imd_we      = 2'($urandom);
            imd_d       = {4'($urandom), 32'($urandom), 32'($urandom)};
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ibex_ex_issue.md
# ibex_ex_issue

Issue and retire controller sitting in the ID stage in front of the execute block. It accepts one decoded instruction at a time and drives the execute block's unit-select, enable and first-cycle controls. It owns the two 34-bit intermediate-value registers that multi-cycle ALU and mult/div operations write back through the imd_val interface. It also captures the execute result into a registered writeback port, honouring writeback backpressure and flushes.

## Interface
Parameters:
- RV32M, 2: 0 = no M extension (MULT/DIV classes are illegal); 1/2/3 = M extension present.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- instr_valid_i  in  1  decoded instruction offered.
- instr_ready_o  out  1  instruction accepted this cycle when high with instr_valid_i.
- op_class_i  in  2  0 = ALU single-cycle, 1 = ALU multi-cycle, 2 = MULT, 3 = DIV.
- rf_waddr_i  in  5  destination register.
- rf_we_i  in  1  instruction writes the register file.
- flush_i  in  1  kill the in-flight operation.
- mult_en_o, div_en_o, mult_sel_o, div_sel_o  out  1 each  execute-block mult/div controls.
- alu_instr_first_cycle_o  out  1  first EXEC cycle of the current operation.
- multdiv_ready_id_o  out  1  ID can accept the result this cycle.
- ex_valid_i  in  1  execute result valid.
- result_ex_i  in  32  execute result.
- imd_val_we_i  in  2  per-slot write enables from EX.
- imd_val_d_i  in  68  slot1 = [67:34], slot0 = [33:0].
- imd_val_q_o  out  68  registered intermediate values, same packing.
- wb_ready_i  in  1  writeback can take data.
- wb_valid_o  out  1  registered writeback strobe, one cycle.
- wb_we_o  out  1  latched rf_we_i.
- wb_waddr_o  out  5  latched destination.
- wb_wdata_o  out  32  latched result.
- illegal_o  out  1  one-cycle pulse for a MULT/DIV op when RV32M = 0.
- exec_cycles_o  out  6  EXEC cycles of the last retired op, saturating at 63.
- busy_o  out  1  state is EXEC.

## Operation
- States: IDLE, EXEC. Reset state is IDLE.
- instr_ready_o = IDLE | (EXEC & ex_valid_i & wb_ready_i & ~flush_i). It is combinational.
- Accept: latch op_class, rf_waddr and rf_we, then go to EXEC.
  - Exception: when RV32M = 0 and the class is MULT or DIV, stay in / return to IDLE, pulse illegal_o on the next cycle, and produce no writeback.
- In EXEC:
  - mult_sel_o = (class == 2) and div_sel_o = (class == 3), both gated to 0 when RV32M = 0.
  - mult_en_o and div_en_o equal their sel in EXEC.
  - alu_instr_first_cycle_o is high only in the first EXEC cycle.
  - multdiv_ready_id_o = wb_ready_i.
- Retire: in EXEC with ex_valid_i & wb_ready_i & ~flush_i.
  - Next cycle: wb_valid_o = 1, wb_wdata_o = result_ex_i, wb_waddr_o / wb_we_o come from the latched fields, and exec_cycles_o = cycle count.
  - Next state is EXEC if a new instruction is accepted in the same cycle, otherwise IDLE.
- ex_valid_i & ~wb_ready_i: stay in EXEC, no writeback, first-cycle stays low. EX holds its result because multdiv_ready_id_o is low.
- Cycle counter:
  - Set to 1 on entering EXEC, including on a back-to-back accept.
  - Incremented each further EXEC cycle, saturating at 63.
- Flush: in EXEC, go to IDLE next cycle. Enables and sels drop that next cycle, there is no writeback, and exec_cycles_o is unchanged. In IDLE, flush has no effect on state.
- imd registers:
  - slot[i] <= imd_val_d_i slice when imd_val_we_i[i] & EXEC.
  - Writes outside EXEC are ignored.
  - Not cleared on accept or flush.
- Outputs that are 0 during reset: wb_*, exec_cycles_o, imd_val_q_o, illegal_o, and all enables and sels. instr_ready_o reads 1 during reset (the state is IDLE).

## Timing
- Single-cycle ALU op: accepted in cycle N, EXEC in N+1, wb_valid_o in N+2.
- Back-to-back single-cycle ops sustain one per cycle.
- Multi-cycle op with ex_valid_i in EXEC cycle k: wb_valid_o one cycle after the retire cycle, exec_cycles_o = k.
- wb_valid_o is never high for two consecutive cycles for the same op.
- flush_i takes priority over retire in the same cycle.
- Async reset mid-EXEC: immediate return to IDLE with all outputs at reset values.

## Test plan
- ALU single op (class 0, waddr 5, EX returns 0x0000_002A in the same EXEC cycle) -> wb_valid_o pulse 2 cycles after accept, wb_waddr_o = 5, wb_wdata_o = 0x2A, exec_cycles_o = 1.
- Three back-to-back class-0 ops with results 1, 2, 3 -> instr_ready_o held high, wb_valid_o high for 3 consecutive cycles with data 1, 2, 3.
- DIV op, ex_valid_i on EXEC cycle 37, imd_val_we_i = 2'b11 with distinct data each cycle:
  - div_en_o/div_sel_o high for 37 cycles and first-cycle high only in cycle 1.
  - imd_val_q_o tracks the last write.
  - exec_cycles_o = 37.
- MULT op, ex_valid_i high, wb_ready_i low for 4 cycles -> multdiv_ready_id_o low, no wb_valid_o until wb_ready_i rises, then one pulse, exec_cycles_o = 5.
- flush_i in EXEC cycle 3 of a DIV -> IDLE next cycle, div_en_o low, no wb_valid_o, exec_cycles_o keeps its previous value. A flush coinciding with ex_valid_i also gives no writeback.
- RV32M = 0 with a class-2 op -> illegal_o one-cycle pulse, mult_en_o never high, no wb_valid_o. Reset asserted mid-EXEC -> all outputs return to 0 immediately.
